// File: rtl/aes_round_seq.sv
// Iterative AES block sequencer around an external combinational round core.
// One core pass per clock. The sequencer adds the key-whitening XOR that the
// core does not cover, and handshakes a block in and a result out.
//   encrypt: IDLE -> PRE (st ^= rk[0]) -> ROUND x NR (keys 1..NR) -> DONE
//   decrypt: IDLE -> ROUND x NR (keys NR..1) -> POST (st ^= rk[0]) -> DONE
module aes_round_seq #(
  parameter int NR = 10,  // core passes per block, 10..14
  parameter int IW = 4    // round-key index width, must hold NR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  input  logic          in_dec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy,
  output logic [IW-1:0] rk_idx,
  input  logic [127:0]  rk_data,
  output logic [127:0]  core_in,
  output logic [127:0]  core_key,
  output logic          core_dec,
  output logic          core_nomix,
  input  logic [127:0]  core_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ROUND,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [IW-1:0] NR_I  = IW'(NR);
  localparam logic [IW-1:0] ONE_I = IW'(1);

  state_t        state;
  logic [IW-1:0] rnd;         // 1..NR while in ROUND
  logic [127:0]  st;          // block state, fed straight into the core
  logic          dec;         // direction latched at accept
  logic          last_round;

  assign last_round = (rnd == NR_I);

  // Handshake and status flags decode directly from the state register.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_data  = st;

  // Core wiring: the core sees the state register and the key store output.
  assign core_in  = st;
  assign core_key = rk_data;
  assign core_dec = dec;

  // Round-key index and MixColumns bypass for the current pass.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    rk_idx     = '0;
    core_nomix = 1'b0;
    if (state == S_ROUND) begin
      if (dec) begin
        // Decrypt walks keys NR..1; the first pass is the one without
        // InvMixColumns. NR+1-rnd stays within 1..NR in IW bits.
        rk_idx     = NR_I + ONE_I - rnd;
        core_nomix = (rnd == ONE_I);
      end else begin
        rk_idx     = rnd;
        core_nomix = last_round;
      end
    end
  end

  // Block sequencer: accept, whiten, run NR core passes, present result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rnd   <= '0;
      st    <= '0;
      dec   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            st    <= in_data;
            dec   <= in_dec;
            rnd   <= ONE_I;
            state <= in_dec ? S_ROUND : S_PRE;
          end
        end
        S_PRE: begin
          st    <= st ^ rk_data;
          state <= S_ROUND;
        end
        S_ROUND: begin
          st <= core_out;
          if (last_round) begin
            state <= dec ? S_POST : S_DONE;
          end else begin
            rnd <= rnd + ONE_I;
          end
        end
        S_POST: begin
          st    <= st ^ rk_data;
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
            rnd   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq. Supplies an AES-128 key store (expanded
// from the FIPS-197 C.1 key) and a behavioural round core matching the pass
// structure the sequencer expects, then checks the C.1 vectors, latency,
// key-index order, backpressure, back-to-back timing, reset and ignored input.
module tb_aes_round_seq;

  localparam int NR = 10;
  localparam int IW = 4;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'hffeeddccbbaa99887766554433221100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic          in_dec;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          busy;
  logic [IW-1:0] rk_idx;
  logic [127:0]  rk_data;
  logic [127:0]  core_in;
  logic [127:0]  core_key;
  logic          core_dec;
  logic          core_nomix;
  logic [127:0]  core_out;

  logic [127:0]  rk_mem [16];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;

  aes_round_seq #(.NR(NR), .IW(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dec     (in_dec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data),
    .core_in    (core_in),
    .core_key   (core_key),
    .core_dec   (core_dec),
    .core_nomix (core_nomix),
    .core_out   (core_out)
  );

  always #5 clk = ~clk;

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] p = a;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x = gf_inv(b);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  // Byte i of a block, FIPS order; state[r][c] is byte 4c+r.
  function automatic logic [7:0] gb(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] x);
    logic [127:0] y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = sbox(gb(x, 4*((c + r) % 4) + r));
    return y;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] x);
    logic [127:0] y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = inv_sbox(gb(x, 4*((c - r + 4) % 4) + r));
    return y;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] x, input logic inv);
    logic [127:0] y = '0;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(x, 4*c); a1 = gb(x, 4*c+1); a2 = gb(x, 4*c+2); a3 = gb(x, 4*c+3);
      if (!inv) begin
        y[127-8*(4*c)   -: 8] = gf_mul(a0, 2) ^ gf_mul(a1, 3) ^ a2 ^ a3;
        y[127-8*(4*c+1) -: 8] = a0 ^ gf_mul(a1, 2) ^ gf_mul(a2, 3) ^ a3;
        y[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gf_mul(a2, 2) ^ gf_mul(a3, 3);
        y[127-8*(4*c+3) -: 8] = gf_mul(a0, 3) ^ a1 ^ a2 ^ gf_mul(a3, 2);
      end else begin
        y[127-8*(4*c)   -: 8] = gf_mul(a0, 14) ^ gf_mul(a1, 11) ^ gf_mul(a2, 13) ^ gf_mul(a3, 9);
        y[127-8*(4*c+1) -: 8] = gf_mul(a0, 9) ^ gf_mul(a1, 14) ^ gf_mul(a2, 11) ^ gf_mul(a3, 13);
        y[127-8*(4*c+2) -: 8] = gf_mul(a0, 13) ^ gf_mul(a1, 9) ^ gf_mul(a2, 14) ^ gf_mul(a3, 11);
        y[127-8*(4*c+3) -: 8] = gf_mul(a0, 11) ^ gf_mul(a1, 13) ^ gf_mul(a2, 9) ^ gf_mul(a3, 14);
      end
    end
    return y;
  endfunction

  // Round core: encrypt = SubBytes, ShiftRows, [MixColumns], AddRoundKey;
  // decrypt = AddRoundKey, [InvMixColumns], InvShiftRows, InvSubBytes.
  function automatic logic [127:0] core_model(input logic [127:0] x, input logic [127:0] k,
                                              input logic d, input logic nomix);
    logic [127:0] t;
    if (!d) begin
      t = sub_shift(x);
      if (!nomix) t = mix(t, 1'b0);
      return t ^ k;
    end
    t = x ^ k;
    if (!nomix) t = mix(t, 1'b1);
    return inv_shift_sub(t);
  endfunction

  // Textbook AES-128 cipher for blocks without a published vector.
  function automatic logic [127:0] aes_enc_ref(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk_mem[0];
    for (int r = 1; r < NR; r++) s = mix(sub_shift(s), 1'b0) ^ rk_mem[r];
    return sub_shift(s) ^ rk_mem[NR];
  endfunction

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  assign rk_data  = rk_mem[rk_idx];
  assign core_out = core_model(core_in, core_key, core_dec, core_nomix);

  // ---------------- bench helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offers a block and returns just after the accepting edge.
  task automatic send(input logic [127:0] d, input logic dir);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("send_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_dec   = dir;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 60) begin tick(); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    int           nacc, nout;
    int           acc [3];
    logic         was_ready;
    logic [127:0] blk [3];
    logic [127:0] expv [3];

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dec = 1'b0; out_ready = 1'b0;
    key_expand(KEY);
    #3;
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_rk_idx",    rk_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 encrypt with exact latency.
    send(PT, 1'b0);
    wait_out(n);
    check("enc_latency",   n, 11);
    check("enc_out_valid", out_valid, 1);
    check("enc_out_data",  out_data, CT);
    out_ready = 1'b1;
    tick();
    check("enc_drained",   out_valid, 0);
    check("enc_in_ready",  in_ready, 1);
    out_ready = 1'b0;

    // FIPS-197 C.1 decrypt with key-index and nomix trace.
    send(CT, 1'b1);
    for (int k = 0; k <= NR; k++) begin
      check($sformatf("dec_rk_idx_%0d", k), rk_idx, (k < NR) ? NR - k : 0);
      check($sformatf("dec_nomix_%0d", k), core_nomix, (k == 0) ? 1 : 0);
      tick();
    end
    check("dec_out_valid", out_valid, 1);
    check("dec_out_data",  out_data, PT);

    // Backpressure: result held for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("bp_data_%0d", i),     out_data, PT);
      check($sformatf("bp_valid_%0d", i),    out_valid, 1);
      check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      check($sformatf("bp_busy_%0d", i),     busy, 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_released",  out_valid, 0);
    check("bp_in_ready",  in_ready, 1);
    check("bp_idle_busy", busy, 0);

    // Back-to-back: in_valid held high over three blocks.
    blk[0] = PT;  expv[0] = CT;
    blk[1] = CT;  expv[1] = PT;
    blk[2] = PT2; expv[2] = aes_enc_ref(PT2);
    nacc = 0; nout = 0;
    in_valid = 1'b1; in_data = blk[0]; in_dec = 1'b0;
    for (int t = 0; t < 200 && nout < 3; t++) begin
      was_ready = in_ready;
      tick();
      if (was_ready && in_valid) begin
        acc[nacc] = cyc;
        nacc++;
        if (nacc < 3) begin
          in_data = blk[nacc];
          in_dec  = (nacc == 1);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check($sformatf("b2b_data_%0d", nout), out_data, expv[nout]);
        nout++;
      end
    end
    in_valid = 1'b0;
    check("b2b_outputs", nout, 3);
    check("b2b_accepts", nacc, 3);
    check("b2b_gap_01", acc[1] - acc[0], NR + 3);
    check("b2b_gap_12", acc[2] - acc[1], NR + 3);
    tick();

    // Asynchronous reset during ROUND rnd=5, then a clean decrypt.
    send(PT, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("mid_rk_idx", rk_idx, 5);
    check("mid_busy",   busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy",      busy, 0);
    check("arst_rk_idx",    rk_idx, 0);
    check("arst_in_ready",  in_ready, 1);
    check("arst_out_data",  out_data, 0);
    #2 rst_n = 1'b1;
    tick();
    send(CT, 1'b1);
    wait_out(n);
    check("post_rst_latency", n, 11);
    check("post_rst_data",    out_data, PT);
    tick();

    // Input activity while busy is ignored.
    send(PT2, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_dec   = ~in_dec;
      check($sformatf("ign_in_ready_%0d", i), in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wait_out(n);
    check("ign_out_valid", out_valid, 1);
    check("ign_out_data",  out_data, expv[2]);
    tick();
    check("ign_idle", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Iterative sequencer that drives one shared combinational AES round core: a full encrypt or decrypt of one 128-bit block, one core pass per clock.
- Reads round keys from an external combinational round-key store by index.
- Adds the stand-alone key-whitening XOR that the core does not cover.
- Faces the upstream block source and downstream sink with valid/ready handshakes.

Parameters:
- NR, 10, number of core passes per block (10/12/14 for AES-128/192/256); legal range 10..14.
- IW, 4, width of round-key index; must hold NR.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input block offered.
- in_ready  output  1  sequencer can accept a block.
- in_data  input  128  plaintext or ciphertext.
- in_dec  input  1  1 = decrypt, 0 = encrypt; sampled with in_data.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts the result.
- out_data  output  128  result block.
- busy  output  1  block in flight (any state other than IDLE).
- rk_idx  output  IW  round-key index to the key store.
- rk_data  input  128  key store data for rk_idx, same cycle (combinational read).
- core_in  output  128  state fed to the round core.
- core_key  output  128  round key to the core; equals rk_data.
- core_dec  output  1  core direction; equals the latched dec bit.
- core_nomix  output  1  core skips (Inv)MixColumns this pass.
- core_out  input  128  core result, same cycle.

Behaviour:
- Reset (asynchronous, rst_n low) clears the following immediately:
  - state to IDLE; round counter rnd to 0; state register st to 0; dec latch to 0.
  - in_ready = 1, out_valid = 0, busy = 0, out_data = 0, rk_idx = 0.
- Reset mid-block discards the block; there is no partial output.
- Core wiring:
  - core_in = st at all times.
  - core_key = rk_data; core_dec = dec latch.
  - The core is purely combinational, so each pass costs exactly one cycle.
- States: IDLE, PRE, ROUND, POST, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: st <= in_data, dec <= in_dec, rnd <= 1.
  - Next state: PRE if encrypting, ROUND if decrypting.
- PRE (encrypt only):
  - rk_idx = 0; st <= st ^ rk_data; next ROUND.
- ROUND:
  - Encrypt: rk_idx = rnd, core_nomix = (rnd == NR).
  - Decrypt: rk_idx = NR+1-rnd, core_nomix = (rnd == 1).
  - st <= core_out.
  - If rnd == NR: go to DONE when encrypting, POST when decrypting. Otherwise rnd <= rnd+1.
- POST (decrypt only):
  - rk_idx = 0; st <= st ^ rk_data; next DONE.
- DONE:
  - out_valid = 1; out_data = st, held stable while out_valid & !out_ready.
  - On out_ready: go to IDLE, rnd <= 0.
  - in_ready stays 0 in DONE; there is no overlap of output drain and new accept.
- Latency:
  - The block is accepted on edge E; out_valid rises after edge E+NR+1 (11 cycles for NR=10) in both directions.
  - Minimum block-to-block period is NR+3 cycles with out_ready held high.
- Outside PRE, ROUND and POST: rk_idx = 0 and core_nomix = 0.
- in_data and in_dec are ignored while in_ready = 0; there is no queuing.
- Key store contents must be stable while busy = 1. Changing them mid-block is out of contract.
- Width rules:
  - rnd is IW bits and never exceeds NR.
  - Decrypt index NR+1-rnd is computed in IW bits; its range is 1..NR with no wrap.

Test Plan:
- FIPS-197 C.1 encrypt: key store loaded with the expansion of key 000102..0f; in_data 00112233445566778899aabbccddeeff, in_dec=0 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rises exactly 11 cycles after accept.
- FIPS-197 C.1 decrypt: in_data 69c4e0d86a7b0430d8cdb78070b4c55a, in_dec=1 -> out_data 00112233445566778899aabbccddeeff; rk_idx sequence 10,9,...,1,0 and core_nomix high only on the first ROUND cycle.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, busy=1 throughout; the block is released on the first out_ready=1 cycle and in_ready=1 the next cycle.
- Back-to-back: in_valid held high with 3 blocks, out_ready=1 -> accepts spaced exactly NR+3=13 cycles apart; all outputs match the reference model.
- Reset mid-operation: assert rst_n=0 during ROUND rnd=5 -> out_valid, busy, rk_idx drop to 0 asynchronously; after release the next block completes correctly.
- Ignored input: toggle in_valid and in_data during ROUND -> no effect on the result; in_ready stays 0.
